// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALUOp width and the bundled control word
// produced by the control unit and carried down the pipeline.
package mips_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    typedef struct packed {
        logic               reg_dst;
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/deteccion_riesgos.sv
// Load-use hazard comparator: the load sitting in EX writes a register that the
// instruction in ID is about to read. Purely combinational.
module deteccion_riesgos #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic             id_uses_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);

    // $0 is hardwired to zero, so a load targeting it can never create a dependency.
    assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i
                      & (rs_match | rt_match);

endmodule

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold and flush.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module registro_id_ex #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = mips_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_RegDst,
    input  logic               id_Branch,
    input  logic               id_MemRead,
    input  logic               id_MemToReg,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic               id_RegWrite,
    input  logic               id_UsesRt,
    input  logic [DATA_W-1:0]  id_Pc4,
    input  logic [DATA_W-1:0]  id_Rd1,
    input  logic [DATA_W-1:0]  id_Rd2,
    input  logic [DATA_W-1:0]  id_Imm,
    input  logic [REG_W-1:0]   id_Rs,
    input  logic [REG_W-1:0]   id_Rt,
    input  logic [REG_W-1:0]   id_Rd,
    input  logic [5:0]         id_Funct,
    input  logic               flush,
    input  logic               ext_stall,
    output logic               stall_out,
    output logic               ex_valid,
    output logic               ex_RegDst,
    output logic               ex_Branch,
    output logic               ex_MemRead,
    output logic               ex_MemToReg,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic               ex_MemWrite,
    output logic               ex_ALUSrc,
    output logic               ex_RegWrite,
    output logic [DATA_W-1:0]  ex_Pc4,
    output logic [DATA_W-1:0]  ex_Rd1,
    output logic [DATA_W-1:0]  ex_Rd2,
    output logic [DATA_W-1:0]  ex_Imm,
    output logic [REG_W-1:0]   ex_Rs,
    output logic [REG_W-1:0]   ex_Rt,
    output logic [REG_W-1:0]   ex_Rd,
    output logic [5:0]         ex_Funct
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]        bubble_cnt
`endif
);

    import mips_pkg::*;

    ctrl_t              id_ctrl;
    ctrl_t              ctrl_q, ctrl_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  pc4_q, pc4_d;
    logic [DATA_W-1:0]  rd1_q, rd1_d;
    logic [DATA_W-1:0]  rd2_q, rd2_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [REG_W-1:0]   rs_q, rs_d;
    logic [REG_W-1:0]   rt_q, rt_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic [5:0]         funct_q, funct_d;
    logic               load_use;
    logic               insert_bubble;

    assign id_ctrl = '{
        reg_dst:    id_RegDst,
        branch:     id_Branch,
        mem_read:   id_MemRead,
        mem_to_reg: id_MemToReg,
        alu_op:     id_ALUOp,
        mem_write:  id_MemWrite,
        alu_src:    id_ALUSrc,
        reg_write:  id_RegWrite
    };

    deteccion_riesgos #(
        .REG_W (REG_W)
    ) u_deteccion_riesgos (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (id_valid),
        .id_uses_rt_i  (id_UsesRt),
        .id_rs_i       (id_Rs),
        .id_rt_i       (id_Rt),
        .load_use_o    (load_use)
    );

    // A flush overrides the stall: the dependent instruction is being killed anyway.
    assign stall_out     = ext_stall | (load_use & ~flush);
    assign insert_bubble = flush | load_use | ~id_valid;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        if (!ext_stall) begin
            pc4_d   = id_Pc4;
            rd1_d   = id_Rd1;
            rd2_d   = id_Rd2;
            imm_d   = id_Imm;
            rs_d    = id_Rs;
            rt_d    = id_Rt;
            rd_d    = id_Rd;
            funct_d = id_Funct;
            if (insert_bubble) begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
            end else begin
                valid_d = 1'b1;
                ctrl_d  = id_ctrl;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data fields are reset too so every ex_* output reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Only hazard bubbles are counted; flush bubbles are a branch cost, not a load-use cost.
    always_comb begin
        cnt_d = cnt_q;
        if (!ext_stall && !flush && load_use) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;
`endif

    assign ex_valid    = valid_q;
    assign ex_RegDst   = ctrl_q.reg_dst;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemToReg = ctrl_q.mem_to_reg;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_Pc4      = pc4_q;
    assign ex_Rd1      = rd1_q;
    assign ex_Rd2      = rd2_q;
    assign ex_Imm      = imm_q;
    assign ex_Rs       = rs_q;
    assign ex_Rt       = rt_q;
    assign ex_Rd       = rd_q;
    assign ex_Funct    = funct_q;

endmodule

// File: tb/tb_registro_id_ex.sv
// Self-checking bench for registro_id_ex: directed scenarios plus randomized traffic
// against a behavioural model of the EX-stage slot.
module tb_registro_id_ex;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               id_valid, id_RegDst, id_Branch, id_MemRead, id_MemToReg;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic               id_MemWrite, id_ALUSrc, id_RegWrite, id_UsesRt;
    logic [DATA_W-1:0]  id_Pc4, id_Rd1, id_Rd2, id_Imm;
    logic [REG_W-1:0]   id_Rs, id_Rt, id_Rd;
    logic [5:0]         id_Funct;
    logic               flush, ext_stall;
    logic               stall_out;
    logic               ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [DATA_W-1:0]  ex_Pc4, ex_Rd1, ex_Rd2, ex_Imm;
    logic [REG_W-1:0]   ex_Rs, ex_Rt, ex_Rd;
    logic [5:0]         ex_Funct;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]        bubble_cnt;
`endif

    always #5 clk = ~clk;

    registro_id_ex #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .ALUOP_W (ALUOP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_RegDst   (id_RegDst),
        .id_Branch   (id_Branch),
        .id_MemRead  (id_MemRead),
        .id_MemToReg (id_MemToReg),
        .id_ALUOp    (id_ALUOp),
        .id_MemWrite (id_MemWrite),
        .id_ALUSrc   (id_ALUSrc),
        .id_RegWrite (id_RegWrite),
        .id_UsesRt   (id_UsesRt),
        .id_Pc4      (id_Pc4),
        .id_Rd1      (id_Rd1),
        .id_Rd2      (id_Rd2),
        .id_Imm      (id_Imm),
        .id_Rs       (id_Rs),
        .id_Rt       (id_Rt),
        .id_Rd       (id_Rd),
        .id_Funct    (id_Funct),
        .flush       (flush),
        .ext_stall   (ext_stall),
        .stall_out   (stall_out),
        .ex_valid    (ex_valid),
        .ex_RegDst   (ex_RegDst),
        .ex_Branch   (ex_Branch),
        .ex_MemRead  (ex_MemRead),
        .ex_MemToReg (ex_MemToReg),
        .ex_ALUOp    (ex_ALUOp),
        .ex_MemWrite (ex_MemWrite),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_RegWrite (ex_RegWrite),
        .ex_Pc4      (ex_Pc4),
        .ex_Rd1      (ex_Rd1),
        .ex_Rd2      (ex_Rd2),
        .ex_Imm      (ex_Imm),
        .ex_Rs       (ex_Rs),
        .ex_Rt       (ex_Rt),
        .ex_Rd       (ex_Rd),
        .ex_Funct    (ex_Funct)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // What the EX stage is expected to hold.
    typedef struct {
        logic               valid, reg_dst, branch, mem_read, mem_to_reg;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write, alu_src, reg_write;
        logic [DATA_W-1:0]  pc4, rd1, rd2, imm;
        logic [REG_W-1:0]   rs, rt, rd;
        logic [5:0]         funct;
    } ex_model_t;

    ex_model_t   exp_ex;
    logic [31:0] exp_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [159:0] dut_vec;

    assign dut_vec = {ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_ALUOp,
                      ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Pc4, ex_Rd1, ex_Rd2, ex_Imm,
                      ex_Rs, ex_Rt, ex_Rd, ex_Funct};

    function automatic logic [159:0] model_vec(ex_model_t m);
        return {m.valid, m.reg_dst, m.branch, m.mem_read, m.mem_to_reg, m.alu_op,
                m.mem_write, m.alu_src, m.reg_write, m.pc4, m.rd1, m.rd2, m.imm,
                m.rs, m.rt, m.rd, m.funct};
    endfunction

    // The ID instruction needs a value that the load in EX has not yet fetched.
    function automatic logic model_load_use();
        logic reads_it;
        if (!(exp_ex.valid && exp_ex.mem_read) || exp_ex.rt == 0 || !id_valid) return 1'b0;
        reads_it = (exp_ex.rt == id_Rs) || (id_UsesRt && exp_ex.rt == id_Rt);
        return reads_it;
    endfunction

    function automatic logic model_stall();
        return ext_stall || (model_load_use() && !flush);
    endfunction

    task automatic model_reset();
        exp_ex  = '{default: '0};
        exp_cnt = '0;
    endtask

    task automatic tick();
        ex_model_t nxt;
        logic      lu;
        nxt = exp_ex;
        lu  = model_load_use();
        if (!ext_stall) begin
            nxt = '{default: '0};
            nxt.pc4 = id_Pc4; nxt.rd1 = id_Rd1; nxt.rd2 = id_Rd2; nxt.imm = id_Imm;
            nxt.rs = id_Rs; nxt.rt = id_Rt; nxt.rd = id_Rd; nxt.funct = id_Funct;
            if (id_valid && !flush && !lu) begin
                nxt.valid = 1'b1;
                nxt.reg_dst = id_RegDst; nxt.branch = id_Branch; nxt.mem_read = id_MemRead;
                nxt.mem_to_reg = id_MemToReg; nxt.alu_op = id_ALUOp; nxt.mem_write = id_MemWrite;
                nxt.alu_src = id_ALUSrc; nxt.reg_write = id_RegWrite;
            end
            if (lu && !flush) exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        exp_ex = nxt;
    endtask

    task automatic rand_instr(int unsigned reg_max);
        id_valid    = 1'b1;
        id_RegDst   = 1'($urandom);
        id_Branch   = 1'($urandom);
        id_MemRead  = 1'($urandom);
        id_MemToReg = 1'($urandom);
        id_ALUOp    = ALUOP_W'($urandom);
        id_MemWrite = 1'($urandom);
        id_ALUSrc   = 1'($urandom);
        id_RegWrite = 1'($urandom);
        id_UsesRt   = 1'($urandom);
        id_Pc4      = $urandom;
        id_Rd1      = $urandom;
        id_Rd2      = $urandom;
        id_Imm      = $urandom;
        id_Rs       = REG_W'($urandom_range(reg_max, 0));
        id_Rt       = REG_W'($urandom_range(reg_max, 0));
        id_Rd       = REG_W'($urandom_range(reg_max, 0));
        id_Funct    = 6'($urandom);
    endtask

    // Order: RegDst Branch MemRead MemToReg ALUOp MemWrite ALUSrc RegWrite UsesRt.
    task automatic set_ctrl(logic rdst, logic br, logic mrd, logic m2r, logic [ALUOP_W-1:0] op,
                            logic mwr, logic asrc, logic rwr, logic urt);
        id_RegDst = rdst; id_Branch = br; id_MemRead = mrd; id_MemToReg = m2r; id_ALUOp = op;
        id_MemWrite = mwr; id_ALUSrc = asrc; id_RegWrite = rwr; id_UsesRt = urt;
    endtask

    task automatic load_lw(logic [REG_W-1:0] rt);
        rand_instr(31);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        id_Rt = rt;
    endtask

    task automatic load_add(logic [REG_W-1:0] rs, logic [REG_W-1:0] rt);
        rand_instr(31);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        id_Rs = rs;
        id_Rt = rt;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (dut_vec !== '0) begin
            $display("FAIL reset_hold: outputs %h, expected 0", dut_vec);
            n_bad++;
        end
        rst_n = 1'b1;
        load_add(5'd1, 5'd2);
        tick();
        n_cmp++;
        if (dut_vec !== model_vec(exp_ex) || ex_RegWrite !== 1'b1) begin
            $display("FAIL reset_first_capture: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
        #2 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (dut_vec !== '0 || stall_out !== 1'b0) begin
            $display("FAIL reset_async: outputs %h stall %b, expected 0", dut_vec, stall_out);
            n_bad++;
        end
`ifdef ID_EX_PERF_CNT_EN
        n_cmp++;
        if (bubble_cnt !== 32'd0) begin
            $display("FAIL reset_cnt: bubble_cnt %0d, expected 0", bubble_cnt);
            n_bad++;
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if (dut_vec !== '0) begin
            $display("FAIL reset_edge_in_reset: outputs %h, expected 0", dut_vec);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_stall();
        load_lw(5'd7);
        tick();
        load_add(5'd7, 5'd1);
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            $display("FAIL mid_stall_pre: stall_out %b, expected 1", stall_out);
            n_bad++;
        end
        #1 rst_n = 1'b0;
        #1 model_reset();
        n_cmp++;
        if (stall_out !== 1'b0 || dut_vec !== '0) begin
            $display("FAIL mid_stall_reset: stall %b outputs %h, expected 0 / 0", stall_out, dut_vec);
            n_bad++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        rand_instr(31);
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
        id_Rs  = 5'd3;
        id_Imm = 32'h5;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL pass_stall: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (dut_vec !== model_vec(exp_ex) || ex_valid !== 1'b1 || ex_ALUOp !== 3'b010
            || ex_Imm !== 32'h5 || ex_Rs !== 5'd3) begin
            $display("FAIL pass_capture: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        load_lw(5'd8);
        tick();
        load_add(5'd8, 5'd9);
        #1;
        n_cmp++;
        if (stall_out !== 1'b1) begin
            $display("FAIL lu_stall: stall_out %b, expected 1", stall_out);
            n_bad++;
        end
        c0 = exp_cnt;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || dut_vec !== model_vec(exp_ex)) begin
            $display("FAIL lu_bubble: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL lu_single_stall: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
`ifdef ID_EX_PERF_CNT_EN
        n_cmp++;
        if (bubble_cnt !== c0 + 32'd1) begin
            $display("FAIL lu_cnt: bubble_cnt %0d, expected %0d", bubble_cnt, c0 + 32'd1);
            n_bad++;
        end
`endif
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_Rs !== 5'd8 || dut_vec !== model_vec(exp_ex)) begin
            $display("FAIL lu_replay: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
    endtask

    task automatic test_no_false_stall();
        load_lw(5'd0);
        tick();
        load_add(5'd0, 5'd0);
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL nfs_rt_zero: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
        tick();
        load_lw(5'd9);
        tick();
        rand_instr(31);
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        id_Rs = 5'd4;
        id_Rt = 5'd9;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL nfs_bgtz: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || dut_vec !== model_vec(exp_ex)) begin
            $display("FAIL nfs_bgtz_capture: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
    endtask

    task automatic test_flush_load_use();
        logic [31:0] c0;
        load_lw(5'd5);
        tick();
        load_add(5'd5, 5'd6);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL flush_lu_stall: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
        c0 = exp_cnt;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || dut_vec !== model_vec(exp_ex)) begin
            $display("FAIL flush_lu_bubble: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
`ifdef ID_EX_PERF_CNT_EN
        n_cmp++;
        if (bubble_cnt !== c0) begin
            $display("FAIL flush_lu_cnt: bubble_cnt %0d, expected %0d", bubble_cnt, c0);
            n_bad++;
        end
`endif
    endtask

    task automatic test_ext_stall();
        logic [159:0] held;
        load_add(5'd10, 5'd11);
        tick();
        held = model_vec(exp_ex);
        for (int i = 0; i < 3; i++) begin
            rand_instr(31);
            ext_stall = 1'b1;
            flush     = 1'b1;
            #1;
            n_cmp++;
            if (stall_out !== 1'b1) begin
                $display("FAIL ext_stall_out[%0d]: stall_out %b, expected 1", i, stall_out);
                n_bad++;
            end
            tick();
            n_cmp++;
            if (dut_vec !== held) begin
                $display("FAIL ext_stall_hold[%0d]: outputs %h, expected %h", i, dut_vec, held);
                n_bad++;
            end
        end
        ext_stall = 1'b0;
        #1;
        n_cmp++;
        if (stall_out !== 1'b0) begin
            $display("FAIL ext_stall_release: stall_out %b, expected 0", stall_out);
            n_bad++;
        end
        tick();
        flush = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || dut_vec !== model_vec(exp_ex)) begin
            $display("FAIL ext_stall_flush_bubble: outputs %h, expected %h", dut_vec, model_vec(exp_ex));
            n_bad++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_instr(3);
            id_valid   = ($urandom_range(9, 0) != 0);
            id_MemRead = ($urandom_range(2, 0) == 0);
            flush      = ($urandom_range(9, 0) == 0);
            ext_stall  = ($urandom_range(6, 0) == 0);
            #1;
            n_cmp++;
            if (stall_out !== model_stall()) begin
                $display("FAIL rand_stall[%0d]: stall_out %b, expected %b", i, stall_out, model_stall());
                n_bad++;
            end
            tick();
            n_cmp++;
            if (dut_vec !== model_vec(exp_ex)) begin
                $display("FAIL rand_regs[%0d]: outputs %h, expected %h", i, dut_vec, model_vec(exp_ex));
                n_bad++;
            end
`ifdef ID_EX_PERF_CNT_EN
            n_cmp++;
            if (bubble_cnt !== exp_cnt) begin
                $display("FAIL rand_cnt[%0d]: bubble_cnt %0d, expected %0d", i, bubble_cnt, exp_cnt);
                n_bad++;
            end
`endif
        end
        flush     = 1'b0;
        ext_stall = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        ext_stall = 1'b0;
        rand_instr(31);
        id_valid  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_reset_mid_stall();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_load_use();
        test_ext_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
